// File: rtl/opb_master_simulink.sv
// Single-beat OPB bus master: requests the bus, drives one address/data
// phase, then waits for a slave acknowledge, retry, error or timeout.
// Completion status and any read data are returned to the fabric side.
//
// Handshake: user_req is accepted only while idle (user_busy=0). It is not
// queued. Every accepted request produces exactly one user_done pulse,
// with user_err valid in that cycle. The only exception is a reset, which
// aborts the transfer silently.
module opb_master_simulink #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_MAX_RETRY  = 8,
  parameter int C_WDOG       = 32
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  output logic                      M_request,
  output logic                      M_busLock,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic [0:3]                M_BE,
  output logic                      M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  input  logic                      OPB_MGrant,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      user_req,
  input  logic                      user_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   user_addr,
  input  logic [C_OPB_DWIDTH-1:0]   user_wdata,
  input  logic [3:0]                user_be,
  output logic                      user_busy,
  output logic                      user_done,
  output logic                      user_err,
  output logic [C_OPB_DWIDTH-1:0]   user_rdata,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_XFER    = 3'd2,
    S_BACKOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] MAX_RETRY = 8'(C_MAX_RETRY);
  localparam logic [7:0] WDOG_LAST = 8'(C_WDOG - 1);

  state_t                  state;
  logic [7:0]              retry_cnt;
  logic [7:0]              wdog;
  logic                    rnw_q;
  logic [C_OPB_AWIDTH-1:0] addr_q;
  logic [C_OPB_DWIDTH-1:0] wdata_q;
  logic [3:0]              be_q;
  logic [7:0]              retry_nxt;

  assign retry_nxt = retry_cnt + 8'd1;
  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;
  assign dbg_state = state;

  // Transfer sequencer. All bus and user outputs are registered here.
  // Bus vectors are cleared whenever M_select falls, so they stay zero while
  // this master does not own the bus.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state      <= S_IDLE;
      retry_cnt  <= '0;
      wdog       <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      M_request  <= 1'b0;
      {M_select, M_RNW, M_BE, M_ABus, M_DBus} <= '0;
      user_busy  <= 1'b0;
      user_done  <= 1'b0;
      user_err   <= 1'b0;
      user_rdata <= '0;
    end else begin
      user_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (user_req) begin
            rnw_q     <= user_rnw;
            addr_q    <= user_addr;
            wdata_q   <= user_wdata;
            be_q      <= user_be;
            retry_cnt <= '0;
            M_request <= 1'b1;
            user_busy <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (OPB_MGrant) begin
            M_request <= 1'b0;
            M_select  <= 1'b1;
            M_RNW     <= rnw_q;
            M_ABus    <= addr_q;
            M_BE      <= be_q;
            M_DBus    <= rnw_q ? '0 : wdata_q;
            wdog      <= '0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          wdog <= wdog + 8'd1;
          if (OPB_xferAck) begin
            // An error acknowledge never updates the read data.
            if (rnw_q && !OPB_errAck) user_rdata <= OPB_DBus;
            user_err  <= OPB_errAck;
            user_done <= 1'b1;
            {M_select, M_RNW, M_BE, M_ABus, M_DBus} <= '0;
            state     <= S_DONE;
          end else if (OPB_retry) begin
            retry_cnt <= retry_nxt;
            {M_select, M_RNW, M_BE, M_ABus, M_DBus} <= '0;
            if (retry_nxt == MAX_RETRY) begin
              user_err  <= 1'b1;
              user_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              state     <= S_BACKOFF;
            end
          end else if (OPB_timeout || wdog == WDOG_LAST) begin
            user_err  <= 1'b1;
            user_done <= 1'b1;
            {M_select, M_RNW, M_BE, M_ABus, M_DBus} <= '0;
            state     <= S_DONE;
          end
        end
        S_BACKOFF: begin
          M_request <= 1'b1;
          state     <= S_REQ;
        end
        S_DONE: begin
          user_busy <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
